// File: rtl/product_drain_if.sv
// product_drain_if -- handshake bundle between the multiplier stage, the
// product accumulator/drain block and the row consumer.
//   prod_valid/prod_ready : product-array beat handshake
//   prod                  : DIM_C x DIM_A array of unsigned ACC_WIDTH products
//   acc_len               : beats per group, sampled on the first beat
//   out_valid/out_ready   : row transfer handshake
//   out_row/out_idx/out_last : summed row, its index, last-row marker
// Modports: master = producer/consumer side, slave = product_drain.
interface product_drain_if #(
  parameter int unsigned DIM_A     = 8,
  parameter int unsigned DIM_C     = 8,
  parameter int unsigned ACC_WIDTH = 12,
  parameter int unsigned SUM_WIDTH = 20,
  parameter int unsigned MAX_LEN   = 16
) ();
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
  localparam int unsigned IDX_W = (DIM_C > 1) ? $clog2(DIM_C) : 1;

  logic                                          prod_valid;
  logic                                          prod_ready;
  logic [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0]    prod;
  logic [LEN_W-1:0]                              acc_len;
  logic                                          out_valid;
  logic                                          out_ready;
  logic [DIM_A-1:0][SUM_WIDTH-1:0]               out_row;
  logic [IDX_W-1:0]                              out_idx;
  logic                                          out_last;

  modport master (
    output prod_valid, prod, acc_len, out_ready,
    input  prod_ready, out_valid, out_row, out_idx, out_last
  );

  modport slave (
    input  prod_valid, prod, acc_len, out_ready,
    output prod_ready, out_valid, out_row, out_idx, out_last
  );
endinterface

// File: rtl/product_drain.sv
// product_drain -- sums acc_len product arrays lane-by-lane into DIM_C x DIM_A
// accumulators, then drains the result one row per transfer.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : product_drain_if.slave (product beats in, summed rows out)
//   busy : high whenever the FSM is not IDLE
// Build option: define SATURATE_EN to clamp accumulator adds at 2^SUM_WIDTH-1;
// otherwise adds wrap modulo 2^SUM_WIDTH.
module product_drain #(
  parameter int unsigned DIM_A     = 8,
  parameter int unsigned DIM_C     = 8,
  parameter int unsigned ACC_WIDTH = 12,
  parameter int unsigned SUM_WIDTH = 20,
  parameter int unsigned MAX_LEN   = 16
) (
  input  logic            clk,
  input  logic            rst,
  product_drain_if.slave  bus,
  output logic            busy
);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
  localparam int unsigned IDX_W = (DIM_C > 1) ? $clog2(DIM_C) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN} state_t;

  state_t                                     state;
  logic [DIM_C-1:0][DIM_A-1:0][SUM_WIDTH-1:0] acc;
  logic [DIM_C-1:0][DIM_A-1:0][SUM_WIDTH-1:0] acc_nxt;
  logic [LEN_W-1:0]                           count;
  logic [LEN_W-1:0]                           len;
  logic [LEN_W-1:0]                           len_in;
  logic [LEN_W-1:0]                           count_inc;
  logic [IDX_W-1:0]                           ptr;
  logic [IDX_W-1:0]                           ptr_inc;
  logic                                       beat;

  // Ready is a decode of the state register, forced low while in reset.
  assign bus.prod_ready = ~rst & (state != S_DRAIN);
  assign beat           = bus.prod_valid & bus.prod_ready;
  assign count_inc      = count + LEN_W'(1);
  assign ptr_inc        = ptr + IDX_W'(1);

  // Effective group length: 0 means one beat, oversize clamps to MAX_LEN.
  always_comb begin
    len_in = bus.acc_len;
    if (bus.acc_len == '0) begin
      len_in = LEN_W'(1);
    end else if (bus.acc_len > LEN_W'(MAX_LEN)) begin
      len_in = LEN_W'(MAX_LEN);
    end
  end

  // Next accumulator values; the first beat of a group loads instead of adds.
`ifdef SATURATE_EN
  logic [SUM_WIDTH:0] sum_ext;
  always_comb begin
    acc_nxt = '0;
    sum_ext = '0;
    for (int r = 0; r < int'(DIM_C); r++) begin
      for (int a = 0; a < int'(DIM_A); a++) begin
        sum_ext = ((state == S_IDLE) ? (SUM_WIDTH+1)'(0) : {1'b0, acc[r][a]})
                  + (SUM_WIDTH+1)'(bus.prod[r][a]);
        acc_nxt[r][a] = sum_ext[SUM_WIDTH] ? {SUM_WIDTH{1'b1}} : sum_ext[SUM_WIDTH-1:0];
      end
    end
  end
`else
  always_comb begin
    acc_nxt = '0;
    for (int r = 0; r < int'(DIM_C); r++) begin
      for (int a = 0; a < int'(DIM_A); a++) begin
        acc_nxt[r][a] = ((state == S_IDLE) ? SUM_WIDTH'(0) : acc[r][a])
                        + SUM_WIDTH'(bus.prod[r][a]);
      end
    end
  end
`endif

  // Control FSM with registered row outputs. Row 0 on DRAIN entry comes from
  // acc_nxt so the final beat's contribution is already included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      acc           <= '0;
      count         <= '0;
      len           <= '0;
      ptr           <= '0;
      busy          <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_row   <= '0;
      bus.out_idx   <= '0;
      bus.out_last  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (beat) begin
            acc   <= acc_nxt;
            len   <= len_in;
            count <= LEN_W'(1);
            busy  <= 1'b1;
            if (len_in == LEN_W'(1)) begin
              state         <= S_DRAIN;
              ptr           <= '0;
              bus.out_valid <= 1'b1;
              bus.out_row   <= acc_nxt[0];
              bus.out_idx   <= '0;
              bus.out_last  <= (DIM_C == 1);
            end else begin
              state <= S_ACCUM;
            end
          end
        end
        S_ACCUM: begin
          if (beat) begin
            acc   <= acc_nxt;
            count <= count_inc;
            if (count_inc == len) begin
              state         <= S_DRAIN;
              ptr           <= '0;
              bus.out_valid <= 1'b1;
              bus.out_row   <= acc_nxt[0];
              bus.out_idx   <= '0;
              bus.out_last  <= (DIM_C == 1);
            end
          end
        end
        S_DRAIN: begin
          if (bus.out_ready) begin
            if (bus.out_last) begin
              state         <= S_IDLE;
              ptr           <= '0;
              busy          <= 1'b0;
              bus.out_valid <= 1'b0;
              bus.out_row   <= '0;
              bus.out_idx   <= '0;
              bus.out_last  <= 1'b0;
            end else begin
              ptr          <= ptr_inc;
              bus.out_row  <= acc[ptr_inc];
              bus.out_idx  <= ptr_inc;
              bus.out_last <= (ptr_inc == IDX_W'(DIM_C - 1));
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/product_drain.md
PRODUCT_DRAIN -- requirements
Module: product_drain

Interface
REQ-001 SHALL have parameter DIM_A, default 8, meaning product columns per row (input lanes).
REQ-002 SHALL have parameter DIM_C, default 8, meaning product rows (weight lanes).
REQ-003 SHALL have parameter ACC_WIDTH, default 12, meaning unsigned width of each incoming product.
REQ-004 SHALL have parameter SUM_WIDTH, default 20, meaning width of each accumulator; SUM_WIDTH >= ACC_WIDTH.
REQ-005 SHALL have parameter MAX_LEN, default 16, meaning maximum beats per accumulation; LEN_W = $clog2(MAX_LEN+1).
REQ-006 SHALL have port clk, input, 1, meaning the single clock.
REQ-007 SHALL have port rst, input, 1, meaning reset; asynchronous and active-high.
REQ-008 SHALL have port prod_valid, input, 1, meaning a product array is offered.
REQ-009 SHALL have port prod_ready, output, 1, meaning the block accepts a product array this cycle.
REQ-010 SHALL have port prod, input, DIM_C x DIM_A x ACC_WIDTH, meaning the product array from the multiplier stage.
REQ-011 SHALL have port acc_len, input, LEN_W, meaning the number of beats to sum, sampled on the first beat of a group.
REQ-012 SHALL have port out_valid, output, 1, meaning out_row holds a finished row.
REQ-013 SHALL have port out_ready, input, 1, meaning the downstream accepts the row.
REQ-014 SHALL have port out_row, output, DIM_A x SUM_WIDTH, meaning the summed row.
REQ-015 SHALL have port out_idx, output, $clog2(DIM_C), meaning the row index of out_row.
REQ-016 SHALL have port out_last, output, 1, meaning out_row is row DIM_C-1.
REQ-017 SHALL have port busy, output, 1, meaning the state is not IDLE.

Function
REQ-018 SHALL implement an FSM with states IDLE, ACCUM and DRAIN.
REQ-019 SHALL define a beat as prod_valid && prod_ready, and a row transfer as out_valid && out_ready.
REQ-020 SHALL drive prod_ready=1 in IDLE and ACCUM and prod_ready=0 in DRAIN.
REQ-021 SHALL drive out_valid=1 only in DRAIN.
REQ-022 On an IDLE beat, SHALL load every accumulator with its zero-extended product, latch len = max(acc_len,1) and set count=1.
REQ-023 From that IDLE beat, SHALL go to DRAIN if len==1 and otherwise to ACCUM.
REQ-024 On each ACCUM beat, SHALL add each product to its accumulator and increment count.
REQ-025 When count reaches len on an ACCUM beat, SHALL go to DRAIN on the next edge.
REQ-026 SHALL treat an acc_len above MAX_LEN as MAX_LEN; the value is latched once and later changes are ignored.
REQ-027 On entry to DRAIN, SHALL set the row pointer to 0; out_row = accumulator row [ptr], out_idx = ptr, out_last = (ptr == DIM_C-1).
REQ-028 On each row transfer, SHALL increment ptr; after the transfer with out_last=1, SHALL go to IDLE.
REQ-029 While out_valid=1 and out_ready=0, SHALL hold out_row, out_idx and out_last stable.
REQ-030 Latency SHALL be: first row valid on the cycle after the final beat; then one row per cycle while out_ready=1; DIM_C cycles minimum in DRAIN.
REQ-031 In IDLE and ACCUM, out_row, out_idx and out_last SHALL be 0.

Reset
REQ-032 While rst=1, SHALL put the FSM in IDLE and clear the accumulators, count, len and ptr; out_valid=0, out_row=0, out_idx=0, out_last=0, busy=0.
REQ-033 While rst=1, SHALL drive prod_ready=0.
REQ-034 An rst assertion in ACCUM or DRAIN SHALL discard partial sums and unsent rows without error.

Configuration
REQ-035 With SATURATE_EN defined, each accumulator add SHALL clamp to 2^SUM_WIDTH-1 on overflow.
REQ-036 Without SATURATE_EN, adds SHALL wrap modulo 2^SUM_WIDTH.

Verification
REQ-037 acc_len=1, one beat with all prods=5, out_ready=1 -> 8 rows of all-5, out_idx 0..7, out_last only on idx 7, busy low afterwards.
REQ-038 acc_len=4, beats with prod=1,2,3,4 each across all lanes -> every out_row lane=10; prod_ready=0 throughout DRAIN.
REQ-039 DRAIN with out_ready toggling 1,0,0,1 -> row held stable during stalls; no row lost or duplicated.
REQ-040 SUM_WIDTH=12, acc_len=2, prod=4095 twice -> 4095 with SATURATE_EN, 4094 without.
REQ-041 rst asserted after 2 of 4 beats, then a fresh acc_len=1 group with prod=7 -> outputs 0 during reset, then all lanes=7.
REQ-042 acc_len=0, prod=9 -> treated as one beat; all lanes=9.
